rr_grant_arbiter8: RTL and testbench

Eight-requester round-robin arbiter with grant hold, release handshake and hold-timeout. It shares one downstream resource among eight clients. It registers a 3-bit winner index and expands it to a one-hot grant vector through a `decoder3to8` instance, with `enable` driven by `grant_valid`. The block sits between the client request lines and the resource's select and enable inputs.

---
 rtl/rr_grant_arbiter8.sv | 112 +++++++++++
 tb/tb_rr_grant_arbiter8.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter8.sv
// Eight-client round-robin arbiter with grant hold, done/withdraw release and hold timeout.
// Latency: one cycle from request sampled in IDLE to grant; one cycle from release to grant drop.
// Backpressure: none; the owner holds the grant until it releases or the hold limit revokes it.

module decoder3to8 (
    input  logic [2:0] sel_i,
    input  logic       enable_i,
    output logic [7:0] out_o
);
    assign out_o = enable_i ? (8'h01 << sel_i) : 8'h00;
endmodule

module rr_grant_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    localparam logic       HOLD_EN    = (MAX_HOLD != 0);

    logic [0:0] state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    logic       win_vld;
    logic [2:0] win_idx;
    logic [2:0] scan_idx;
    logic       owner_req;
    logic       hold_hit;
    logic       release_now;

    // Scan from the farthest offset down so the nearest requester after ptr wins.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = ptr_q;
        scan_idx = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            scan_idx = ptr_q + 3'(k);
            if (req[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    assign owner_req   = req[idx_q];
    assign hold_hit    = HOLD_EN && (hold_q == HOLD_LIMIT);
    assign release_now = done || !owner_req || hold_hit;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            if (win_vld) begin
                state_d = GRANT;
                idx_d   = win_idx;
                hold_d  = 8'd1;
            end
        end else begin
            if (release_now) begin
                state_d   = IDLE;
                ptr_d     = idx_q + 3'd1;
                hold_d    = 8'd0;
                // Only a pure hold-limit release is reported as forced.
                timeout_d = !done && owner_req;
            end else if (hold_q != 8'hFF) begin
                hold_d = hold_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            idx_q     <= 3'd0;
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_valid = (state_q == GRANT);
    assign grant_idx   = idx_q;
    assign timeout     = timeout_q;

    decoder3to8 u_dec (
        .sel_i    (idx_q),
        .enable_i (grant_valid),
        .out_o    (grant)
    );
endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// Directed bench for rr_grant_arbiter8: one instance with MAX_HOLD=4, one with the timeout disabled.
module tb_rr_grant_arbiter8;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req, req0;
    logic       done, done0;
    logic [7:0] grant, grant0;
    logic [2:0] grant_idx, grant_idx0;
    logic       grant_valid, grant_valid0;
    logic       timeout, timeout0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_grant_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    rr_grant_arbiter8 #(.MAX_HOLD(0)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .req         (req0),
        .done        (done0),
        .grant       (grant0),
        .grant_idx   (grant_idx0),
        .grant_valid (grant_valid0),
        .timeout     (timeout0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] one;
        one  = 8'h01;
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        req0 = 8'h00;
        done0 = 1'b0;
        cyc();
        cyc();
        chk("rst_grant", 32'(grant), 32'h00);
        chk("rst_valid", 32'(grant_valid), 32'h0);
        chk("rst_idx", 32'(grant_idx), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);

        // single request, then confirm ptr moved to 5 via the next winner
        rst = 1'b0;
        req = 8'h10;
        cyc();
        chk("single_grant", 32'(grant), 32'h10);
        chk("single_idx", 32'(grant_idx), 32'h4);
        chk("single_valid", 32'(grant_valid), 32'h1);
        done = 1'b1;
        cyc();
        chk("single_release", 32'(grant), 32'h00);
        done = 1'b0;
        req  = 8'h11;
        cyc();
        chk("ptr_after_4", 32'(grant), 32'h01);
        done = 1'b1;
        req  = 8'h00;
        cyc();
        chk("release_0", 32'(grant), 32'h00);
        done = 1'b0;

        // rotation from ptr=0 with all clients requesting
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk($sformatf("rot_grant%0d", i), 32'(grant), 32'(one << (i % 8)));
            done = 1'b1;
            cyc();
            chk($sformatf("rot_gap%0d", i), 32'(grant), 32'h00);
            done = 1'b0;
        end

        // wrap-around: after client 6, client 0 beats client 6
        req = 8'h40;
        cyc();
        chk("wrap_g6", 32'(grant), 32'h40);
        done = 1'b1;
        cyc();
        done = 1'b0;
        req  = 8'h41;
        cyc();
        chk("wrap_g0", 32'(grant), 32'h01);
        done = 1'b1;
        cyc();
        done = 1'b0;
        cyc();
        chk("wrap_g6_again", 32'(grant), 32'h40);
        done = 1'b1;
        cyc();
        done = 1'b0;
        req  = 8'h00;
        cyc();
        chk("wrap_idle", 32'(grant_valid), 32'h0);

        // timeout after exactly 4 held cycles
        req = 8'h08;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("hold%0d_grant", i), 32'(grant), 32'h08);
            chk($sformatf("hold%0d_to", i), 32'(timeout), 32'h0);
        end
        cyc();
        chk("to_grant", 32'(grant), 32'h00);
        chk("to_pulse", 32'(timeout), 32'h1);
        cyc();
        chk("regrant3", 32'(grant), 32'h08);
        chk("to_cleared", 32'(timeout), 32'h0);

        // done coincides with hold limit: normal release
        cyc();
        cyc();
        cyc();
        chk("limit_grant", 32'(grant), 32'h08);
        done = 1'b1;
        cyc();
        chk("done_at_limit_grant", 32'(grant), 32'h00);
        chk("done_at_limit_to", 32'(timeout), 32'h0);
        done = 1'b0;
        cyc();
        chk("regrant3_b", 32'(grant), 32'h08);

        // owner withdraws
        req = 8'h00;
        cyc();
        chk("withdraw_valid", 32'(grant_valid), 32'h0);
        chk("withdraw_to", 32'(timeout), 32'h0);
        chk("withdraw_idx", 32'(grant_idx), 32'h3);

        // done in IDLE ignored
        done = 1'b1;
        cyc();
        chk("idle_done", 32'(grant), 32'h00);
        done = 1'b0;

        // non-owner request changes do not disturb the grant (ptr=4)
        req = 8'h20;
        cyc();
        chk("own5", 32'(grant), 32'h20);
        req = 8'h2F;
        cyc();
        chk("own5_hold", 32'(grant), 32'h20);
        chk("own5_idx", 32'(grant_idx), 32'h5);

        // reset mid-grant
        rst = 1'b1;
        cyc();
        chk("midrst_grant", 32'(grant), 32'h00);
        chk("midrst_idx", 32'(grant_idx), 32'h0);
        chk("midrst_to", 32'(timeout), 32'h0);
        rst = 1'b0;
        req = 8'h21;
        cyc();
        chk("midrst_win0", 32'(grant), 32'h01);
        req = 8'h00;
        cyc();

        // timeout disabled: hold well past the counter saturation point
        req0 = 8'h80;
        for (int i = 0; i < 300; i++) begin
            cyc();
            chk("nolimit_grant", 32'(grant0), 32'h80);
            chk("nolimit_to", 32'(timeout0), 32'h0);
        end
        done0 = 1'b1;
        cyc();
        chk("nolimit_release", 32'(grant0), 32'h00);
        chk("nolimit_release_to", 32'(timeout0), 32'h0);
        done0 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
